aes256_sched: RTL and testbench

AES256_SCHED -- requirements
Module: aes256_sched

---
 rtl/aes256_sched.sv | 235 +++++++++++++++++++++++
 tb/tb_aes256_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_sched.sv
// Two-requester scheduler around one combinational AES-256 core.
// Operands are registered at request acceptance and held on the core for
// CORE_WAIT cycles (multicycle path) before the ciphertext is captured.
// Optional feature macro: AES_SCHED_RR_EN -- round-robin arbitration between
// the two requesters. Undefined (default): fixed priority, requester 0 wins.
// Byte order on key/msg/ciphertext: AES byte 0 sits in the most significant byte.

module aes256 (
  input  logic [255:0] i_key,
  input  logic [127:0] i_msg,
  output logic [127:0] o_ct
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    inv  = gmul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] aes256_encrypt(input logic [255:0] key,
                                                  input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rcon;
    logic [127:0] s;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rcon = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r < 14; r++)
      s = mix_columns(shift_rows(sub_bytes(s))) ^
          {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    s = shift_rows(sub_bytes(s)) ^ {w[56], w[57], w[58], w[59]};
    return s;
  endfunction

  // Full 14-round encryption, purely combinational
  always_comb o_ct = aes256_encrypt(i_key, i_msg);

endmodule

// state   | meaning
// IDLE    | no job; arbitrate and accept one request
// WAIT    | operands held on the core, counting down CORE_WAIT cycles
// DONE    | result valid for the owner until it is consumed
module aes256_sched #(
  parameter int CORE_WAIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [255:0] req0_key,
  input  logic [127:0] req0_msg,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic [127:0] resp0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [255:0] req1_key,
  input  logic [127:0] req1_msg,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [127:0] resp1_data,
  output logic         busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [7:0] LP_WAIT_LOAD = 8'(CORE_WAIT - 1);

  logic [1:0]   r_state;
  logic [7:0]   r_cnt;
  logic         r_owner;
  logic [255:0] r_key;
  logic [127:0] r_msg;
  logic [127:0] r_result;
  logic [127:0] w_core_ct;
  logic         w_idle;
  logic         w_grant;
  logic         w_req_hs;
  logic         w_resp_hs;

  aes256 u_core (
    .i_key (r_key),
    .i_msg (r_msg),
    .o_ct  (w_core_ct)
  );

`ifdef AES_SCHED_RR_EN
  logic r_last;

  // Contention goes to whoever was not served last; a lone requester always wins
  always_comb w_grant = (req0_valid && req1_valid) ? ~r_last : ~req0_valid;

  // Pointer remembers the last accepted requester
  always_ff @(posedge clk) begin
    if (rst)           r_last <= 1'b1;
    else if (w_req_hs) r_last <= w_grant;
  end
`else
  // Fixed priority: requester 1 only wins when requester 0 is idle
  always_comb w_grant = ~req0_valid;
`endif

  // Handshake and status decode
  always_comb begin
    w_idle      = (r_state == ST_IDLE);
    req0_ready  = w_idle && req0_valid && !w_grant;
    req1_ready  = w_idle && req1_valid && w_grant;
    w_req_hs    = req0_ready || req1_ready;
    resp0_valid = (r_state == ST_DONE) && !r_owner;
    resp1_valid = (r_state == ST_DONE) && r_owner;
    w_resp_hs   = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);
    resp0_data  = r_result;
    resp1_data  = r_result;
    busy        = !w_idle;
  end

  // Sequencer: accept, hold operands for CORE_WAIT cycles, capture, deliver
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_owner  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_hs) begin
            r_state <= ST_WAIT;
            r_cnt   <= LP_WAIT_LOAD;
            r_owner <= w_grant;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 8'd0) begin
            r_result <= w_core_ct;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_DONE: begin
          if (w_resp_hs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Operands latch only at acceptance so later input changes cannot disturb the core
  always_ff @(posedge clk) begin
    if (!rst && w_req_hs) begin
      r_key <= w_grant ? req1_key : req0_key;
      r_msg <= w_grant ? req1_msg : req0_msg;
    end
  end

endmodule

// File: tb/tb_aes256_sched.sv
// Directed bench for aes256_sched: instance A uses CORE_WAIT=1, instance B CORE_WAIT=4.
// Arbitration expectations follow AES_SCHED_RR_EN as compiled.

module tb_aes256_sched;

  localparam logic [255:0] K_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] M_C3 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K_SP = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] M_SP = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C_SP = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

  logic clk = 1'b0;
  logic rst;

  logic a_req0_valid, a_req0_ready, a_resp0_valid, a_resp0_ready;
  logic a_req1_valid, a_req1_ready, a_resp1_valid, a_resp1_ready, a_busy;
  logic [255:0] a_req0_key, a_req1_key;
  logic [127:0] a_req0_msg, a_req1_msg, a_resp0_data, a_resp1_data;

  logic b_req0_valid, b_req0_ready, b_resp0_valid, b_resp0_ready;
  logic b_req1_valid, b_req1_ready, b_resp1_valid, b_resp1_ready, b_busy;
  logic [255:0] b_req0_key, b_req1_key;
  logic [127:0] b_req0_msg, b_req1_msg, b_resp0_data, b_resp1_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes256_sched #(.CORE_WAIT(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_key(a_req0_key), .req0_msg(a_req0_msg),
    .resp0_valid(a_resp0_valid), .resp0_ready(a_resp0_ready), .resp0_data(a_resp0_data),
    .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_key(a_req1_key), .req1_msg(a_req1_msg),
    .resp1_valid(a_resp1_valid), .resp1_ready(a_resp1_ready), .resp1_data(a_resp1_data),
    .busy(a_busy)
  );

  aes256_sched #(.CORE_WAIT(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_key(b_req0_key), .req0_msg(b_req0_msg),
    .resp0_valid(b_resp0_valid), .resp0_ready(b_resp0_ready), .resp0_data(b_resp0_data),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_key(b_req1_key), .req1_msg(b_req1_msg),
    .resp1_valid(b_resp1_valid), .resp1_ready(b_resp1_ready), .resp1_data(b_resp1_data),
    .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got a=%b b=%b expected 0", a_busy, b_busy); end
    checks++; if ({a_resp0_valid, a_resp1_valid, b_resp0_valid, b_resp1_valid} !== 4'b0000) begin failures++; $display("FAIL reset_resp_valid: got %b expected 0000", {a_resp0_valid, a_resp1_valid, b_resp0_valid, b_resp1_valid}); end
    checks++; if ({a_req0_ready, a_req1_ready, b_req0_ready, b_req1_ready} !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b expected 0000", {a_req0_ready, a_req1_ready, b_req0_ready, b_req1_ready}); end
    checks++; if (a_resp0_data !== 128'h0 || b_resp1_data !== 128'h0) begin failures++; $display("FAIL reset_result: got a=%h b=%h expected 0", a_resp0_data, b_resp1_data); end
    rst = 1'b0;
  endtask

  task automatic test_fips_c3();
    a_req0_key = K_C3; a_req0_msg = M_C3; a_req0_valid = 1'b1;
    #1;
    checks++; if (a_req0_ready !== 1'b1 || a_req1_ready !== 1'b0) begin failures++; $display("FAIL c3_accept: got r0=%b r1=%b expected 1 0", a_req0_ready, a_req1_ready); end
    tick();
    a_req0_valid = 1'b0; a_req0_msg = '1;
    #1;
    checks++; if (a_resp0_valid !== 1'b0 || a_busy !== 1'b1) begin failures++; $display("FAIL c3_t1: got valid=%b busy=%b expected 0 1", a_resp0_valid, a_busy); end
    tick();
    checks++; if (a_resp0_valid !== 1'b1 || a_resp1_valid !== 1'b0) begin failures++; $display("FAIL c3_t2_valid: got v0=%b v1=%b expected 1 0", a_resp0_valid, a_resp1_valid); end
    checks++; if (a_resp0_data !== C_C3) begin failures++; $display("FAIL c3_data: got %h expected %h", a_resp0_data, C_C3); end
    a_resp0_ready = 1'b1;
    tick();
    a_resp0_ready = 1'b0;
    checks++; if (a_busy !== 1'b0 || a_resp0_valid !== 1'b0) begin failures++; $display("FAIL c3_release: got busy=%b valid=%b expected 0 0", a_busy, a_resp0_valid); end
  endtask

  task automatic test_req1_vector();
    a_req1_key = K_SP; a_req1_msg = M_SP; a_req1_valid = 1'b1;
    #1;
    checks++; if (a_req1_ready !== 1'b1 || a_req0_ready !== 1'b0) begin failures++; $display("FAIL sp_accept: got r1=%b r0=%b expected 1 0", a_req1_ready, a_req0_ready); end
    tick();
    a_req1_valid = 1'b0;
    tick();
    checks++; if (a_resp1_valid !== 1'b1 || a_resp0_valid !== 1'b0) begin failures++; $display("FAIL sp_valid: got v1=%b v0=%b expected 1 0", a_resp1_valid, a_resp0_valid); end
    checks++; if (a_resp1_data !== C_SP) begin failures++; $display("FAIL sp_data: got %h expected %h", a_resp1_data, C_SP); end
    a_resp1_ready = 1'b1;
    tick();
    a_resp1_ready = 1'b0;
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL sp_release: got busy=%b expected 0", a_busy); end
  endtask

  task automatic test_hold();
    b_req0_key = K_C3; b_req0_msg = M_C3; b_req0_valid = 1'b1;
    #1;
    checks++; if (b_req0_ready !== 1'b1) begin failures++; $display("FAIL hold_accept: got %b expected 1", b_req0_ready); end
    tick();
    b_req0_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (b_resp0_valid !== 1'b0) begin failures++; $display("FAIL hold_early_valid: cycle T+%0d got 1 expected 0", k); end
      tick();
    end
    checks++; if (b_resp0_valid !== 1'b1) begin failures++; $display("FAIL hold_latency: got valid=%b at T+5 expected 1", b_resp0_valid); end
    b_req0_key = K_SP; b_req0_msg = M_SP; b_req0_valid = 1'b1;
    b_req1_key = K_SP; b_req1_msg = M_SP; b_req1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++; if (b_resp0_valid !== 1'b1 || b_resp0_data !== C_C3) begin failures++; $display("FAIL hold_stable: cycle %0d got valid=%b data=%h expected 1 %h", k, b_resp0_valid, b_resp0_data, C_C3); end
      checks++; if (b_req0_ready !== 1'b0 || b_req1_ready !== 1'b0 || b_busy !== 1'b1) begin failures++; $display("FAIL hold_ready_busy: cycle %0d got r0=%b r1=%b busy=%b expected 0 0 1", k, b_req0_ready, b_req1_ready, b_busy); end
      tick();
    end
    b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_resp0_ready = 1'b1;
    tick();
    b_resp0_ready = 1'b0;
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL hold_release: got busy=%b expected 0", b_busy); end
  endtask

  task automatic test_contention();
    int  cnt;
    logic exp_g;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b_req0_key = K_C3; b_req0_msg = M_C3; b_req0_valid = 1'b1;
    b_req1_key = K_SP; b_req1_msg = M_SP; b_req1_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
`ifdef AES_SCHED_RR_EN
      exp_g = n[0];
`else
      exp_g = 1'b0;
`endif
      #1;
      checks++; if (b_req0_ready !== ~exp_g || b_req1_ready !== exp_g) begin failures++; $display("FAIL arb_grant: txn %0d got r0=%b r1=%b expected grant %0d", n, b_req0_ready, b_req1_ready, exp_g); end
      tick();
      cnt = 0;
      while (!(b_resp0_valid || b_resp1_valid) && cnt < 20) begin
        tick();
        cnt++;
      end
      checks++; if (cnt != 4) begin failures++; $display("FAIL arb_latency: txn %0d got %0d cycles after T+1 expected 4", n, cnt); end
      checks++; if (b_resp0_valid !== ~exp_g || b_resp1_valid !== exp_g) begin failures++; $display("FAIL arb_owner: txn %0d got v0=%b v1=%b expected owner %0d", n, b_resp0_valid, b_resp1_valid, exp_g); end
      checks++; if (b_resp1_data !== (exp_g ? C_SP : C_C3)) begin failures++; $display("FAIL arb_data: txn %0d got %h expected %h", n, b_resp1_data, exp_g ? C_SP : C_C3); end
      b_resp0_ready = 1'b1; b_resp1_ready = 1'b1;
      tick();
      b_resp0_ready = 1'b0; b_resp1_ready = 1'b0;
    end
    b_req0_valid = 1'b0; b_req1_valid = 1'b0;
  endtask

  task automatic test_reset_abort();
    int   cnt;
    logic seen;
    b_req0_key = K_C3; b_req0_msg = M_C3; b_req0_valid = 1'b1;
    tick();
    b_req0_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (b_busy !== 1'b0 || b_resp0_valid !== 1'b0 || b_resp1_valid !== 1'b0) begin failures++; $display("FAIL abort_state: got busy=%b v0=%b v1=%b expected 0 0 0", b_busy, b_resp0_valid, b_resp1_valid); end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (b_resp0_valid || b_resp1_valid || b_busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_resp: got activity=%b expected 0", seen); end
    b_req1_key = K_SP; b_req1_msg = M_SP; b_req1_valid = 1'b1;
    #1;
    checks++; if (b_req1_ready !== 1'b1) begin failures++; $display("FAIL abort_next_accept: got %b expected 1", b_req1_ready); end
    tick();
    b_req1_valid = 1'b0;
    cnt = 0;
    while (!b_resp1_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    checks++; if (b_resp1_valid !== 1'b1 || b_resp1_data !== C_SP) begin failures++; $display("FAIL abort_next_data: got valid=%b data=%h expected 1 %h", b_resp1_valid, b_resp1_data, C_SP); end
    b_resp1_ready = 1'b1;
    tick();
    b_resp1_ready = 1'b0;
  endtask

  task automatic test_non_owner();
    int cnt;
    b_req0_key = K_C3; b_req0_msg = M_C3; b_req0_valid = 1'b1;
    tick();
    b_req0_valid = 1'b0;
    cnt = 0;
    while (!b_resp0_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    checks++; if (b_resp0_valid !== 1'b1) begin failures++; $display("FAIL nonowner_wait: got valid=%b expected 1 within 20 cycles", b_resp0_valid); end
    b_resp1_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (b_resp0_valid !== 1'b1 || b_busy !== 1'b1 || b_resp0_data !== C_C3) begin failures++; $display("FAIL nonowner_ignored: got valid=%b busy=%b data=%h expected 1 1 %h", b_resp0_valid, b_busy, b_resp0_data, C_C3); end
    b_resp1_ready = 1'b0; b_resp0_ready = 1'b1;
    tick();
    b_resp0_ready = 1'b0;
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL nonowner_release: got busy=%b expected 0", b_busy); end
  endtask

  task automatic test_msg_change();
    int cnt;
    b_req0_key = K_C3; b_req0_msg = M_C3; b_req0_valid = 1'b1;
    tick();
    b_req0_valid = 1'b0;
    cnt = 0;
    while (!b_resp0_valid && cnt < 20) begin
      b_req0_msg = {$urandom(), $urandom(), $urandom(), $urandom()};
      b_req0_key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      cnt++;
    end
    checks++; if (b_resp0_valid !== 1'b1 || b_resp0_data !== C_C3) begin failures++; $display("FAIL msgchg_data: got valid=%b data=%h expected 1 %h", b_resp0_valid, b_resp0_data, C_C3); end
    b_resp0_ready = 1'b1;
    tick();
    b_resp0_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_req0_valid = 1'b0; a_req0_key = '0; a_req0_msg = '0; a_resp0_ready = 1'b0;
    a_req1_valid = 1'b0; a_req1_key = '0; a_req1_msg = '0; a_resp1_ready = 1'b0;
    b_req0_valid = 1'b0; b_req0_key = '0; b_req0_msg = '0; b_resp0_ready = 1'b0;
    b_req1_valid = 1'b0; b_req1_key = '0; b_req1_msg = '0; b_resp1_ready = 1'b0;
    test_reset();
    test_fips_c3();
    test_req1_vector();
    test_hold();
    test_contention();
    test_reset_abort();
    test_non_owner();
    test_msg_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
